dram_req_queue: RTL
===================

// Module: dram_req_queue
// PURPOSE
//  Host-side request queue and issue sequencer upstream of the DRAM controller.
//  Buffers host read/write requests in a FIFO and presents them one at a time on
//  the controller's u_en/u_addr/u_cmd/u_data_i interface, holding each until u_cmd_ack.
//  Collects read data (u_data_valid) and returns it to the host in request order,
//  with a timeout error if data never arrives.
// PARAMETERS
//  U_ADDR_WIDTH   13   host/controller address width (bank|row|column)
//  U_DATA_WIDTH   8    data width, both directions
//  QUEUE_DEPTH    8    FIFO entries; power of two, >=2
//  RD_TIMEOUT     255  max cycles in S_WAIT_RD before error; >=1
//  CNT_WIDTH      $clog2(QUEUE_DEPTH+1)  occupancy counter width (derived)
// PORTS
//  u_clk         in   1             clock
//  u_rst_n       in   1             reset; asynchronous, active-low
//  req_valid     in   1             host request valid
//  req_ready     out  1             queue can accept (= !full)
//  req_we        in   1             1 = write, 0 = read
//  req_addr      in   U_ADDR_WIDTH  request address
//  req_wdata     in   U_DATA_WIDTH  write data (ignored for reads)
//  rsp_valid     out  1             one-cycle pulse: read response
//  rsp_data      out  U_DATA_WIDTH  read data; 0 on error
//  rsp_err       out  1             qualifies rsp_valid: read timed out
//  q_count       out  CNT_WIDTH     current FIFO occupancy
//  ctl_en        out  1             to controller u_en
//  ctl_addr      out  U_ADDR_WIDTH  to controller u_addr
//  ctl_cmd       out  1             to controller u_cmd (1 = write)
//  ctl_wdata     out  U_DATA_WIDTH  to controller u_data_i
//  ctl_ack       in   1             from controller u_cmd_ack
//  ctl_busy      in   1             from controller u_busy
//  ctl_rd_data   in   U_DATA_WIDTH  from controller u_data_o
//  ctl_rd_valid  in   1             from controller u_data_valid
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; FIFO empty, FSM in S_IDLE, timeout cnt 0.
//  Push: on req_valid && req_ready, store {we,addr,wdata} at tail. req_ready=0 when
//   count==QUEUE_DEPTH, even if a pop occurs that cycle. Push+pop same cycle: count unchanged.
//  Pointers wrap modulo QUEUE_DEPTH; count carries full/empty (no pointer-compare ambiguity).
//  FSM (registered outputs):
//   S_IDLE: count!=0 && !ctl_busy -> S_ISSUE; load ctl_addr/ctl_cmd/ctl_wdata from head.
//   S_ISSUE: ctl_en=1, fields held stable. On ctl_ack: pop head, ctl_en drops next cycle;
//    write -> S_IDLE; read -> S_WAIT_RD, clear timeout cnt. No timeout in S_ISSUE.
//   S_WAIT_RD: ctl_en=0. ctl_rd_valid -> rsp_valid=1, rsp_data=ctl_rd_data (next cycle), -> S_IDLE.
//    Timeout cnt increments each cycle; at RD_TIMEOUT -> rsp_valid=1, rsp_err=1, rsp_data=0,
//    -> S_IDLE. ctl_rd_valid on same cycle as timeout wins (normal response).
//  Latency: push at edge N -> ctl_en high after edge N+2 (empty queue, ctl_busy=0).
//  One request outstanding at a time; minimum one S_IDLE cycle between requests.
//  ctl_rd_valid outside S_WAIT_RD is ignored. ctl_ack outside S_ISSUE is ignored.
//  rsp_valid/rsp_err are single-cycle pulses; no host backpressure on responses.
//  Reset mid-operation: in-flight request and queued entries discarded, no response issued.
// STRUCTURE
//  dram_pkg: issue FSM state localparams (S_IDLE/S_ISSUE/S_WAIT_RD), entry field
//   offsets, shared width helpers.
//  Sub-module dram_req_fifo: synchronous FIFO (push/pop/count/full/empty), instanced once,
//   entry width 1+U_ADDR_WIDTH+U_DATA_WIDTH. Issue FSM and timeout counter in top.
// TESTING
//  1 Reset mid-read (in S_WAIT_RD): assert u_rst_n=0 -> all outputs 0, req_ready=1, no rsp_valid.
//  2 Write addr 0x0123 data 0xA5, ack 1 cycle after ctl_en -> ctl_cmd=1, ctl_addr=0x0123,
//    ctl_wdata=0xA5 stable until ack; ctl_en low next cycle; q_count back to 0.
//  3 Read 0x0040, ctl_rd_valid with 0x3C 5 cycles after ack -> one rsp_valid pulse,
//    rsp_data=0x3C, rsp_err=0.
//  4 Fill 8 entries with ctl_busy=1 -> req_ready=0, q_count=8; 9th req_valid not accepted;
//    release busy -> all 8 issued in push order, addresses match.
//  5 Read with no ctl_rd_valid, RD_TIMEOUT=255 -> rsp_valid=1, rsp_err=1, rsp_data=0
//    255 cycles after entering S_WAIT_RD; next queued request then issues.
//  6 Push while popping at count=7 -> q_count stays 7; push at count=8 during pop -> refused.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM request queue: issue FSM states and
// the layout of a queued entry {we, addr, wdata}.
package dram_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } issue_state_e;

  function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

  // wdata occupies the low bits, addr sits above it, we is the MSB
  function automatic int unsigned addr_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned we_bit(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/dram_req_fifo.sv
// Synchronous FIFO with an occupancy counter; the counter alone decides
// full/empty so the wrapping pointers never need to be compared.
module dram_req_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dram_req_queue.sv
// Host request queue and issue sequencer in front of the DRAM controller:
// one request in flight at a time, read data returned in order or timed out.
module dram_req_queue
  import dram_pkg::*;
#(
  parameter int unsigned U_ADDR_WIDTH = 13,
  parameter int unsigned U_DATA_WIDTH = 8,
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned RD_TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH    = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                    u_clk,
  input  logic                    u_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [U_ADDR_WIDTH-1:0] req_addr,
  input  logic [U_DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [U_DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic [CNT_WIDTH-1:0]    q_count,
  output logic                    ctl_en,
  output logic [U_ADDR_WIDTH-1:0] ctl_addr,
  output logic                    ctl_cmd,
  output logic [U_DATA_WIDTH-1:0] ctl_wdata,
  input  logic                    ctl_ack,
  input  logic                    ctl_busy,
  input  logic [U_DATA_WIDTH-1:0] ctl_rd_data,
  input  logic                    ctl_rd_valid
);

  localparam int unsigned ENTRY_W  = entry_width(U_ADDR_WIDTH, U_DATA_WIDTH);
  localparam int unsigned ADDR_LSB = addr_lsb(U_DATA_WIDTH);
  localparam int unsigned WE_BIT   = we_bit(U_ADDR_WIDTH, U_DATA_WIDTH);
  localparam int unsigned TMO_W    = $clog2(RD_TIMEOUT + 1);

  logic [ENTRY_W-1:0]      head_entry;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;

  issue_state_e            state_q, state_d;
  logic                    ctl_en_q, ctl_en_d;
  logic [U_ADDR_WIDTH-1:0] ctl_addr_q, ctl_addr_d;
  logic                    ctl_cmd_q, ctl_cmd_d;
  logic [U_DATA_WIDTH-1:0] ctl_wdata_q, ctl_wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [U_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;

  dram_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_WIDTH)
  ) u_fifo (
    .clk   (u_clk),
    .rst_n (u_rst_n),
    .push  (fifo_push),
    .wdata ({req_we, req_addr, req_wdata}),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .count (q_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    ctl_en_d    = ctl_en_q;
    ctl_addr_d  = ctl_addr_q;
    ctl_cmd_d   = ctl_cmd_q;
    ctl_wdata_d = ctl_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !ctl_busy) begin
          state_d     = S_ISSUE;
          ctl_cmd_d   = head_entry[WE_BIT];
          ctl_addr_d  = head_entry[ADDR_LSB +: U_ADDR_WIDTH];
          ctl_wdata_d = head_entry[U_DATA_WIDTH-1:0];
        end
      end
      S_ISSUE: begin
        // an ack only counts once the controller can actually see ctl_en
        if (ctl_en_q && ctl_ack) begin
          fifo_pop = 1'b1;
          ctl_en_d = 1'b0;
          tmo_d    = '0;
          state_d  = ctl_cmd_q ? S_IDLE : S_WAIT_RD;
        end else begin
          ctl_en_d = 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (ctl_rd_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = ctl_rd_data;
          state_d     = S_IDLE;
        end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      state_q     <= S_IDLE;
      ctl_en_q    <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_cmd_q   <= 1'b0;
      ctl_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctl_en_q    <= ctl_en_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_cmd_q   <= ctl_cmd_d;
      ctl_wdata_q <= ctl_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ctl_en    = ctl_en_q;
  assign ctl_addr  = ctl_addr_q;
  assign ctl_cmd   = ctl_cmd_q;
  assign ctl_wdata = ctl_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule
